// File: rtl/dmem_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// dmem_pkg : shared sizes, FSM encoding and port indices for dmem_arbiter
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package dmem_pkg;

    localparam int DMEM_ADDR_W = 4;
    localparam int DMEM_DATA_W = 8;
    localparam int DMEM_DEPTH  = 2 ** DMEM_ADDR_W;

    localparam int PORT_CPU = 0;
    localparam int PORT_DBG = 1;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_e;

endpackage

`default_nettype wire

// File: rtl/dmem_arbiter_if.sv
// ---------------------------------------------------------------------------
// dmem_arbiter_if : requester, clear-control and memory-side signals
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface dmem_arbiter_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) ();

    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_gnt;
    logic              cpu_rvalid;
    logic [DATA_W-1:0] cpu_rdata;

    logic              dbg_req;
    logic              dbg_we;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_wdata;
    logic              dbg_gnt;
    logic              dbg_rvalid;
    logic [DATA_W-1:0] dbg_rdata;

    logic              clr_start;
    logic              clr_busy;
    logic              clr_done;

    logic              mem_c17;
    logic [ADDR_W-1:0] mem_write_select;
    logic [DATA_W-1:0] mem_inp;
    logic [ADDR_W-1:0] mem_read_select;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_gnt, cpu_rvalid, cpu_rdata,
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
        output dbg_gnt, dbg_rvalid, dbg_rdata,
        input  clr_start,
        output clr_busy, clr_done,
        output mem_c17, mem_write_select, mem_inp, mem_read_select,
        input  mem_rdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_gnt, cpu_rvalid, cpu_rdata,
        output dbg_req, dbg_we, dbg_addr, dbg_wdata,
        input  dbg_gnt, dbg_rvalid, dbg_rdata,
        output clr_start,
        input  clr_busy, clr_done,
        input  mem_c17, mem_write_select, mem_inp, mem_read_select,
        output mem_rdata
    );

endinterface

`default_nettype wire

// File: rtl/dmem_arbiter_rr_arb2.sv
// ---------------------------------------------------------------------------
// rr_arb2 : two-input round-robin arbiter; on a tie the port not granted last wins
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rr_arb2 (
    input  wire logic       clk,
    input  wire logic       rst,
    input  wire logic       i_en,
    input  wire logic [1:0] i_req,
    output logic      [1:0] o_gnt
);

    logic       rr_last_q;
    logic       rr_last_d;
    logic [1:0] gnt_d;

    always_comb begin
        gnt_d     = 2'b00;
        rr_last_d = rr_last_q;
        if (i_en) begin
            case (i_req)
                2'b01:   gnt_d = 2'b01;
                2'b10:   gnt_d = 2'b10;
                2'b11:   gnt_d = rr_last_q ? 2'b01 : 2'b10;
                default: gnt_d = 2'b00;
            endcase
        end
        if (gnt_d != 2'b00) begin
            rr_last_d = gnt_d[1];
        end
    end

    // Reset to port 1 so port 0 takes the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_last_q <= 1'b1;
        end else begin
            rr_last_q <= rr_last_d;
        end
    end

    assign o_gnt = gnt_d;

endmodule

`default_nettype wire

// File: rtl/dmem_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_arbiter : shares a 1-cycle-latency data memory between CPU and debug host,
//                with a clear sweep that writes CLR_VALUE to every address
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int                ADDR_W    = DMEM_ADDR_W,
    parameter int                DATA_W    = DMEM_DATA_W,
    parameter logic [DATA_W-1:0] CLR_VALUE = '0
) (
    input  wire logic       clock,
    input  wire logic       reset,
    dmem_arbiter_if.slave   bus
);

    localparam int                DEPTH    = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADR = ADDR_W'(DEPTH - 1);

    state_e            state_q,    state_d;
    logic [ADDR_W-1:0] clr_cnt_q,  clr_cnt_d;
    logic              rd_pend_q,  rd_pend_d;
    logic              rd_port_q,  rd_port_d;
    logic              clr_done_q, clr_done_d;
    logic [ADDR_W-1:0] rsel_q,     rsel_d;
    logic [ADDR_W-1:0] wsel_q,     wsel_d;

    logic              arb_en;
    logic [1:0]        gnt;
    logic              gnt_any;
    logic              gnt_port;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              c17_d;
    logic [DATA_W-1:0] inp_d;

    assign arb_en = (state_q == ST_IDLE) && !reset;

    rr_arb2 u_arb (
        .clk   (clock),
        .rst   (reset),
        .i_en  (arb_en),
        .i_req ({bus.dbg_req, bus.cpu_req}),
        .o_gnt (gnt)
    );

    assign gnt_any   = |gnt;
    assign gnt_port  = gnt[PORT_DBG];
    assign sel_we    = gnt_port ? bus.dbg_we    : bus.cpu_we;
    assign sel_addr  = gnt_port ? bus.dbg_addr  : bus.cpu_addr;
    assign sel_wdata = gnt_port ? bus.dbg_wdata : bus.cpu_wdata;

    always_comb begin
        state_d    = state_q;
        clr_cnt_d  = clr_cnt_q;
        rd_pend_d  = 1'b0;
        rd_port_d  = rd_port_q;
        clr_done_d = 1'b0;
        rsel_d     = rsel_q;
        wsel_d     = wsel_q;
        c17_d      = 1'b0;
        inp_d      = '0;

        case (state_q)
            ST_IDLE: begin
                if (gnt_any) begin
                    if (sel_we) begin
                        c17_d  = 1'b1;
                        wsel_d = sel_addr;
                        inp_d  = sel_wdata;
                    end else begin
                        rsel_d    = sel_addr;
                        rd_pend_d = 1'b1;
                        rd_port_d = gnt_port;
                    end
                end
                // A request granted in the same cycle as clr_start still completes.
                if (bus.clr_start) begin
                    state_d = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                c17_d     = 1'b1;
                wsel_d    = clr_cnt_q;
                inp_d     = CLR_VALUE;
                clr_cnt_d = clr_cnt_q + 1'b1;
                if (clr_cnt_q == LAST_ADR) begin
                    state_d    = ST_IDLE;
                    clr_cnt_d  = '0;
                    clr_done_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Reset silences the memory port in the reset cycle itself.
        if (reset) begin
            c17_d  = 1'b0;
            inp_d  = '0;
            rsel_d = '0;
            wsel_d = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            clr_cnt_q  <= '0;
            rd_pend_q  <= 1'b0;
            rd_port_q  <= 1'b0;
            clr_done_q <= 1'b0;
            rsel_q     <= '0;
            wsel_q     <= '0;
        end else begin
            state_q    <= state_d;
            clr_cnt_q  <= clr_cnt_d;
            rd_pend_q  <= rd_pend_d;
            rd_port_q  <= rd_port_d;
            clr_done_q <= clr_done_d;
            rsel_q     <= rsel_d;
            wsel_q     <= wsel_d;
        end
    end

    assign bus.cpu_gnt    = gnt[PORT_CPU];
    assign bus.dbg_gnt    = gnt[PORT_DBG];
    assign bus.cpu_rvalid = rd_pend_q && !reset && (rd_port_q == 1'(PORT_CPU));
    assign bus.dbg_rvalid = rd_pend_q && !reset && (rd_port_q == 1'(PORT_DBG));
    assign bus.cpu_rdata  = bus.mem_rdata;
    assign bus.dbg_rdata  = bus.mem_rdata;

    assign bus.clr_busy   = (state_q == ST_CLEAR) && !reset;
    assign bus.clr_done   = clr_done_q && !reset;

    assign bus.mem_c17          = c17_d;
    assign bus.mem_write_select = wsel_d;
    assign bus.mem_inp          = inp_d;
    assign bus.mem_read_select  = rsel_d;

endmodule

`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dmem_arbiter : directed scenarios plus random traffic against a behavioural model
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_dmem_arbiter;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    dmem_arbiter_if #(.ADDR_W(4), .DATA_W(8)) bus ();

    dmem_arbiter #(.ADDR_W(4), .DATA_W(8), .CLR_VALUE(8'h00)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // Memory with registered, read-before-write output.
    logic [7:0] mem [16];
    always @(posedge clock) begin
        if (bus.mem_c17) mem[bus.mem_write_select] <= bus.mem_inp;
        bus.mem_rdata <= mem[bus.mem_read_select];
    end

    int n_vec = 0;
    int n_err = 0;

    // Model state
    logic [7:0] ref_mem   [16];
    bit         ref_known [16];
    bit         m_busy    = 0;
    int         m_idx     = 0;
    int         m_last    = 1;
    bit         m_done    = 0;
    bit         m_pend    = 0;
    int         m_pport   = 0;
    logic [7:0] m_pdata   = 8'h00;
    bit         m_pknown  = 0;
    logic [3:0] m_rsel    = 4'h0;

    // Last observed values, for literal checks
    logic       obs_cpu_gnt, obs_dbg_gnt, obs_cpu_rvalid, obs_dbg_rvalid;
    logic [7:0] obs_cpu_rdata, obs_dbg_rdata;
    logic       obs_busy, obs_done;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cycle();
        int         win;
        bit         wr, rd;
        logic [3:0] waddr, raddr;
        logic [7:0] wdat;
        @(negedge clock);
        obs_cpu_gnt    = bus.cpu_gnt;
        obs_dbg_gnt    = bus.dbg_gnt;
        obs_cpu_rvalid = bus.cpu_rvalid;
        obs_dbg_rvalid = bus.dbg_rvalid;
        obs_cpu_rdata  = bus.cpu_rdata;
        obs_dbg_rdata  = bus.dbg_rdata;
        obs_busy       = bus.clr_busy;
        obs_done       = bus.clr_done;

        if (reset) begin
            chk("rst_cpu_gnt", bus.cpu_gnt, 0);
            chk("rst_dbg_gnt", bus.dbg_gnt, 0);
            chk("rst_cpu_rvalid", bus.cpu_rvalid, 0);
            chk("rst_dbg_rvalid", bus.dbg_rvalid, 0);
            chk("rst_c17", bus.mem_c17, 0);
            chk("rst_rsel", bus.mem_read_select, 0);
            chk("rst_wsel", bus.mem_write_select, 0);
            chk("rst_busy", bus.clr_busy, 0);
            chk("rst_done", bus.clr_done, 0);
            @(posedge clock);
            m_busy = 0; m_idx = 0; m_last = 1; m_done = 0; m_pend = 0; m_rsel = 4'h0;
            #1;
            return;
        end

        // Who wins this cycle (-1 = nobody)
        win = -1;
        if (!m_busy) begin
            if (bus.cpu_req && bus.dbg_req) win = (m_last == 0) ? 1 : 0;
            else if (bus.cpu_req)            win = 0;
            else if (bus.dbg_req)            win = 1;
        end
        wr = 0; rd = 0; waddr = 4'h0; wdat = 8'h00; raddr = m_rsel;
        if (m_busy) begin
            wr = 1; waddr = 4'(m_idx); wdat = 8'h00;
        end else if (win >= 0) begin
            if ((win == 0 ? bus.cpu_we : bus.dbg_we)) begin
                wr = 1;
                waddr = (win == 0) ? bus.cpu_addr  : bus.dbg_addr;
                wdat  = (win == 0) ? bus.cpu_wdata : bus.dbg_wdata;
            end else begin
                rd = 1;
                raddr = (win == 0) ? bus.cpu_addr : bus.dbg_addr;
            end
        end

        chk("cpu_gnt", bus.cpu_gnt, (win == 0) ? 1 : 0);
        chk("dbg_gnt", bus.dbg_gnt, (win == 1) ? 1 : 0);
        chk("cpu_rvalid", bus.cpu_rvalid, (m_pend && m_pport == 0) ? 1 : 0);
        chk("dbg_rvalid", bus.dbg_rvalid, (m_pend && m_pport == 1) ? 1 : 0);
        if (m_pend && m_pknown) begin
            if (m_pport == 0) chk("cpu_rdata", bus.cpu_rdata, m_pdata);
            else              chk("dbg_rdata", bus.dbg_rdata, m_pdata);
        end
        chk("mem_c17", bus.mem_c17, wr);
        if (wr) begin
            chk("mem_wsel", bus.mem_write_select, waddr);
            chk("mem_inp", bus.mem_inp, wdat);
        end
        chk("mem_rsel", bus.mem_read_select, raddr);
        chk("clr_busy", bus.clr_busy, m_busy);
        chk("clr_done", bus.clr_done, m_done);

        @(posedge clock);
        m_pend = rd;
        if (rd) begin
            m_pport  = win;
            m_pdata  = ref_mem[raddr];
            m_pknown = ref_known[raddr];
        end
        m_rsel = raddr;
        if (wr) begin
            ref_mem[waddr]   = wdat;
            ref_known[waddr] = 1;
        end
        if (win >= 0) m_last = win;
        m_done = 0;
        if (m_busy) begin
            m_idx++;
            if (m_idx == 16) begin
                m_busy = 0; m_idx = 0; m_done = 1;
            end
        end else if (bus.clr_start) begin
            m_busy = 1; m_idx = 0;
        end
        #1;
    endtask

    task automatic idle_inputs();
        bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = 0; bus.cpu_wdata = 0;
        bus.dbg_req = 0; bus.dbg_we = 0; bus.dbg_addr = 0; bus.dbg_wdata = 0;
        bus.clr_start = 0;
    endtask

    task automatic cpu_read(input logic [3:0] a, output logic [7:0] d);
        bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = a;
        cycle();
        bus.cpu_req = 0;
        cycle();
        d = obs_cpu_rdata;
    endtask

    task automatic fill_all();
        for (int a = 0; a < 16; a++) begin
            bus.dbg_req = 1; bus.dbg_we = 1; bus.dbg_addr = 4'(a); bus.dbg_wdata = 8'(a + 8'h10);
            cycle();
        end
        bus.dbg_req = 0; bus.dbg_we = 0;
    endtask

    initial begin
        logic [7:0] d;
        int busy_cnt, done_cnt, gnt_in_sweep, guard;

        for (int a = 0; a < 16; a++) begin
            ref_known[a] = 0;
            ref_mem[a]   = 8'h00;
        end
        idle_inputs();
        reset = 1;
        cycle();
        cycle();
        chk("reset_busy_lit", obs_busy, 0);
        reset = 0;

        // CPU write then read of address 3
        bus.cpu_req = 1; bus.cpu_we = 1; bus.cpu_addr = 4'd3; bus.cpu_wdata = 8'hA5;
        cycle();
        chk("t1_wr_gnt_lit", obs_cpu_gnt, 1);
        bus.cpu_we = 0;
        cycle();
        chk("t1_rd_gnt_lit", obs_cpu_gnt, 1);
        bus.cpu_req = 0;
        cycle();
        chk("t1_rvalid_lit", obs_cpu_rvalid, 1);
        chk("t1_rdata_lit", obs_cpu_rdata, 8'hA5);
        chk("t1_dbg_rvalid_lit", obs_dbg_rvalid, 0);

        // Round-robin from reset with both ports reading
        reset = 1;
        cycle();
        reset = 0;
        bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 4'd3;
        bus.dbg_req = 1; bus.dbg_we = 0; bus.dbg_addr = 4'd3;
        for (int i = 0; i < 6; i++) begin
            cycle();
            chk("t2_cpu_gnt_lit", obs_cpu_gnt, (i % 2 == 0) ? 1 : 0);
            chk("t2_dbg_gnt_lit", obs_dbg_gnt, (i % 2 == 1) ? 1 : 0);
            if (i > 0) begin
                chk("t2_cpu_rv_lit", obs_cpu_rvalid, (i % 2 == 1) ? 1 : 0);
                chk("t2_dbg_rv_lit", obs_dbg_rvalid, (i % 2 == 0) ? 1 : 0);
            end
        end
        idle_inputs();
        cycle();

        // Fill, then sweep with the host request held throughout
        fill_all();
        bus.clr_start = 1;
        cycle();
        bus.clr_start = 0;
        bus.dbg_req = 1; bus.dbg_we = 0; bus.dbg_addr = 4'd5;
        busy_cnt = 0; gnt_in_sweep = 0; guard = 0;
        cycle();
        while (obs_busy && guard < 40) begin
            busy_cnt++;
            if (obs_dbg_gnt || obs_cpu_gnt) gnt_in_sweep++;
            guard++;
            cycle();
        end
        chk("t3_sweep_len_lit", busy_cnt, 16);
        chk("t3_no_gnt_lit", gnt_in_sweep, 0);
        chk("t4_gnt_after_lit", obs_dbg_gnt, 1);
        chk("t3_done_lit", obs_done, 1);
        bus.dbg_req = 0;
        cycle();
        chk("t4_rvalid_lit", obs_dbg_rvalid, 1);
        chk("t4_rdata_lit", obs_dbg_rdata, 8'h00);
        chk("t3_done_once_lit", obs_done, 0);
        cpu_read(4'd0, d);  chk("t3_rd0_lit", d, 8'h00);
        cpu_read(4'd7, d);  chk("t3_rd7_lit", d, 8'h00);
        cpu_read(4'd15, d); chk("t3_rd15_lit", d, 8'h00);

        // Reset in the middle of a sweep
        fill_all();
        bus.clr_start = 1;
        cycle();
        bus.clr_start = 0;
        for (int i = 0; i < 5; i++) cycle();
        reset = 1;
        cycle();
        reset = 0;
        cycle();
        chk("t5_busy_lit", obs_busy, 0);
        chk("t5_done_lit", obs_done, 0);
        cpu_read(4'd10, d); chk("t5_rd10_lit", d, 8'h1A);
        cpu_read(4'd2, d);  chk("t5_rd2_lit", d, 8'h00);

        // Second clr_start during a sweep is ignored
        bus.clr_start = 1;
        cycle();
        busy_cnt = 0; done_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            bus.clr_start = (i == 3) ? 1'b1 : 1'b0;
            cycle();
            if (obs_busy) busy_cnt++;
            if (obs_done) done_cnt++;
        end
        chk("t6_sweep_len_lit", busy_cnt, 16);
        chk("t6_done_cnt_lit", done_cnt, 1);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            bus.cpu_req   = ($urandom_range(0, 3) != 0);
            bus.cpu_we    = $urandom_range(0, 1);
            bus.cpu_addr  = 4'($urandom_range(0, 15));
            bus.cpu_wdata = 8'($urandom);
            bus.dbg_req   = ($urandom_range(0, 2) == 0);
            bus.dbg_we    = $urandom_range(0, 1);
            bus.dbg_addr  = 4'($urandom_range(0, 15));
            bus.dbg_wdata = 8'($urandom);
            bus.clr_start = ($urandom_range(0, 49) == 0);
            reset         = ($urandom_range(0, 199) == 0);
            cycle();
        end
        reset = 0;
        idle_inputs();
        cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the 16x8 data memory between two requesters: the CPU datapath (port 0) and the debug/loader host (port 1).
- Drives the memory's write enable (c17), write_select, inp and read_select from the granted requester. Returns read data with a valid strobe to the requester that issued the read.
- Contains a clear sequencer that sweeps every address to a fixed value while holding off both requesters.

Parameters:
- ADDR_W, 4, address width; DEPTH = 2**ADDR_W = 16.
- DATA_W, 8, data word width.
- CLR_VALUE, 8'h00, value written to every address by a clear sweep.

Ports:
- clock  in  1  system clock; all state on posedge.
- reset  in  1  synchronous, active-high reset.
- cpu_req  in  1  CPU access request; held until cpu_gnt.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  ADDR_W  CPU address.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_gnt  out  1  access accepted this cycle.
- cpu_rvalid  out  1  cpu_rdata valid this cycle.
- cpu_rdata  out  DATA_W  read data.
- dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_gnt, dbg_rvalid, dbg_rdata: same as the cpu_* ports, for the host.
- clr_start  in  1  single-cycle pulse; requests a clear sweep.
- clr_busy  out  1  sweep in progress.
- clr_done  out  1  one-cycle pulse when the sweep completes.
- mem_c17  out  1  memory write enable.
- mem_write_select  out  ADDR_W  memory write address.
- mem_inp  out  DATA_W  memory write data.
- mem_read_select  out  ADDR_W  memory read address.
- mem_rdata  in  DATA_W  memory registered read output.

Behaviour:
- States: IDLE (arbitrate) and CLEAR. Registers: state, clr_cnt[ADDR_W], rr_last (last granted port), rd_pend, rd_port, clr_done.
- Reset values:
  - state = IDLE, clr_cnt = 0, rr_last = 1 (CPU wins first tie).
  - rd_pend = 0, clr_done = 0, clr_busy = 0.
  - All gnt and rvalid outputs = 0, mem_c17 = 0, mem_* addresses = 0.
- Grant logic in IDLE is combinational from req and rr_last. At most one grant per cycle.
  - Only one port requesting: that port is granted.
  - Both requesting: the port not equal to rr_last is granted.
  - rr_last updates to the granted port at the clock edge.
- Granted write: mem_c17 = 1, mem_write_select = addr, mem_inp = wdata in the same cycle. The memory commits at that edge.
- Granted read: mem_read_select = addr in the same cycle N.
  - Set rd_pend = 1 and rd_port = granted port at the edge.
  - In cycle N+1, the matching rvalid = 1 and rdata = mem_rdata (pass-through). Read latency is 1 cycle.
- With no grant, mem_c17 = 0 and mem_read_select holds its last value.
- Back-to-back reads from either port are allowed, one per cycle. rvalid in cycle N+1 can coincide with a new grant.
- cpu_rdata and dbg_rdata both carry mem_rdata; only rvalid distinguishes the owner.
- A read followed the next cycle by a write to the same address returns the pre-write data.
- clr_start in IDLE:
  - The transition to CLEAR happens at that edge. Any same-cycle request is still granted normally; clr_start does not block the current cycle.
  - In CLEAR: no grants. mem_c17 = 1, mem_write_select = clr_cnt, mem_inp = CLR_VALUE, clr_busy = 1.
  - clr_cnt increments each cycle. After the write at clr_cnt = DEPTH-1: state = IDLE, clr_cnt = 0, clr_done = 1 for the following cycle.
  - The sweep takes exactly DEPTH cycles in CLEAR.
- clr_start while in CLEAR is ignored.
- A read issued in the cycle before CLEAR still completes its rvalid in the first CLEAR cycle.
- Requests held during CLEAR are served starting in the cycle after the last sweep write, with normal round-robin.
- Reset asserted mid-sweep aborts it: IDLE, clr_cnt = 0, no clr_done, pending rvalid dropped. Memory contents are left partially cleared.

Decomposition:
- Shared package dmem_pkg:
  - ADDR_W/DATA_W/DEPTH defaults and the state encoding (ST_IDLE = 1'b0, ST_CLEAR = 1'b1).
  - Port index constants PORT_CPU = 0, PORT_DBG = 1.
- One natural sub-module, rr_arb2: 2-input round-robin grant with an rr_last register, reusable for other shared resources.

Test Plan:
- CPU writes 8'hA5 to addr 3, then reads addr 3 -> cpu_gnt in each request cycle; cpu_rvalid one cycle after the read grant with cpu_rdata = 8'hA5; dbg_rvalid stays 0.
- Both ports request continuously for 6 cycles from reset -> grants alternate CPU, DBG, CPU, DBG, CPU, DBG; each read's rvalid appears on the owning port only.
- Fill addresses 0..15 with addr+8'h10, pulse clr_start -> clr_busy high for exactly 16 cycles and no grants during them; clr_done pulses once; reads of addr 0, 7 and 15 then return 8'h00.
- dbg_req held during a sweep -> dbg_gnt in the cycle after the last sweep write, never before.
- Reset asserted at sweep cycle 5 -> next cycle clr_busy = 0, no clr_done; addr 10 still holds its pre-sweep value.
- clr_start pulsed again mid-sweep -> sweep still ends after 16 total cycles with a single clr_done.
